// File: rtl/icache_refill_if.sv
// rtl/icache_refill_if.sv - AXI4 read address/data channels between the refill engine and memory
//
// Purpose: bundles the AR and R channel signals used by the instruction-cache refill engine.
// Signal names keep the direction prefix as seen from the refill engine (o_ = driven by it).
//   master modport: refill engine side (drives AR valid/addr/len/size/burst and R ready)
//   slave  modport: memory/interconnect side (drives AR ready and R valid/data/resp/last)
interface icache_refill_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int BEAT_WIDTH = 32
);
  logic                  o_axi_arvalid;
  logic                  i_axi_arready;
  logic [ADDR_WIDTH-1:0] o_axi_araddr;
  logic [7:0]            o_axi_arlen;
  logic [2:0]            o_axi_arsize;
  logic [1:0]            o_axi_arburst;
  logic                  i_axi_rvalid;
  logic                  o_axi_rready;
  logic [BEAT_WIDTH-1:0] i_axi_rdata;
  logic [1:0]            i_axi_rresp;
  logic                  i_axi_rlast;

  modport master (
    output o_axi_arvalid, o_axi_araddr, o_axi_arlen, o_axi_arsize, o_axi_arburst, o_axi_rready,
    input  i_axi_arready, i_axi_rvalid, i_axi_rdata, i_axi_rresp, i_axi_rlast
  );

  modport slave (
    input  o_axi_arvalid, o_axi_araddr, o_axi_arlen, o_axi_arsize, o_axi_arburst, o_axi_rready,
    output i_axi_arready, i_axi_rvalid, i_axi_rdata, i_axi_rresp, i_axi_rlast
  );
endinterface

// File: rtl/icache_refill_unit.sv
// rtl/icache_refill_unit.sv - I-cache line refill engine over an AXI4 INCR read burst
//
// Purpose: on an I-cache miss, fetch the line-aligned block as one INCR burst of BEATS beats,
// pack beat k into bits [k*BEAT_WIDTH +: BEAT_WIDTH], and hand the line to fetch with a
// one-cycle write strobe. Errors (bad rresp, short/long burst) end in a one-cycle error pulse.
// Ports:
//   i_clk, i_arst        clock, synchronous active-high reset
//   i_icache_miss        level, fetch stalled on a miss
//   i_read_addr          miss byte address (fetch PC)
//   axi                  AR/R channels (master modport)
//   o_instr_we           one-cycle line write strobe
//   o_instr_block        assembled line, held until the next burst overwrites it
//   o_busy               high whenever the engine is not idle
//   o_refill_error       one-cycle pulse when a burst ends in error
module icache_refill_unit #(
  parameter int ADDR_WIDTH  = 64,
  parameter int BLOCK_WIDTH = 512,
  parameter int BEAT_WIDTH  = 32
) (
  input  logic                   i_clk,
  input  logic                   i_arst,
  input  logic                   i_icache_miss,
  input  logic [ADDR_WIDTH-1:0]  i_read_addr,
  icache_refill_if.master        axi,
  output logic                   o_instr_we,
  output logic [BLOCK_WIDTH-1:0] o_instr_block,
  output logic                   o_busy,
  output logic                   o_refill_error
);
  localparam int BEATS  = BLOCK_WIDTH / BEAT_WIDTH;
  localparam int OFFSET = $clog2(BLOCK_WIDTH / 8);
  localparam int CNT_W  = $clog2(BEATS);
  localparam int SIZE   = $clog2(BEAT_WIDTH / 8);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_FILL = 2'd3;

  logic [1:0]             state;
  logic [ADDR_WIDTH-1:0]  line_addr;
  logic [CNT_W-1:0]       beat_cnt;
  logic                   wrapped;   // all BEATS slots already filled; further beats are overruns
  logic                   err;       // sticky error for the current burst
  logic [BLOCK_WIDTH-1:0] block;
  logic                   beat_fire;
  logic                   beat_err;
  logic                   last_err;
  logic                   addr_match;

  assign axi.o_axi_arvalid = (state == ST_ADDR);
  assign axi.o_axi_araddr  = line_addr;
  assign axi.o_axi_arlen   = 8'(BEATS - 1);
  assign axi.o_axi_arsize  = 3'(SIZE);
  assign axi.o_axi_arburst = 2'b01;
  assign axi.o_axi_rready  = (state == ST_DATA);
  assign o_busy            = (state != ST_IDLE);
  assign o_instr_block     = block;

  always_comb begin
    beat_fire  = (state == ST_DATA) && axi.i_axi_rvalid;
    beat_err   = (axi.i_axi_rresp != 2'b00) || wrapped;
    // Error as it stands including the rlast beat itself: a short burst shows up as a count mismatch.
    last_err   = err || beat_err || (beat_cnt != CNT_W'(BEATS - 1));
    // Stale-miss detection: fetch may have been redirected while the burst was in flight.
    addr_match = (i_read_addr[ADDR_WIDTH-1:OFFSET] == line_addr[ADDR_WIDTH-1:OFFSET]);
  end

  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      state          <= ST_IDLE;
      line_addr      <= '0;
      beat_cnt       <= '0;
      wrapped        <= 1'b0;
      err            <= 1'b0;
      block          <= '0;
      o_instr_we     <= 1'b0;
      o_refill_error <= 1'b0;
    end else begin
      o_instr_we     <= 1'b0;
      o_refill_error <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_icache_miss) begin
            line_addr <= {i_read_addr[ADDR_WIDTH-1:OFFSET], {OFFSET{1'b0}}};
            beat_cnt  <= '0;
            wrapped   <= 1'b0;
            err       <= 1'b0;
            state     <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (axi.i_axi_arready) state <= ST_DATA;
        end
        ST_DATA: begin
          if (beat_fire) begin
            if (!wrapped) block[beat_cnt*BEAT_WIDTH +: BEAT_WIDTH] <= axi.i_axi_rdata;
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == CNT_W'(BEATS - 1)) wrapped <= 1'b1;
            err <= err || beat_err;
            if (axi.i_axi_rlast) begin
              state          <= ST_FILL;
              o_instr_we     <= !last_err && i_icache_miss && addr_match;
              o_refill_error <= last_err;
            end
          end
        end
        ST_FILL: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_icache_refill_unit.sv
// tb/tb_icache_refill_unit.sv - directed self-checking bench for icache_refill_unit
`define CHK(tag, obs, exp) begin checks++; assert ((obs) === (exp)) else begin errors++; $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp)); end end

module tb_icache_refill_unit;
  logic         clk = 1'b0;
  logic         arst;
  logic         miss;
  logic [63:0]  raddr;
  logic         we;
  logic [511:0] blk;
  logic         busy;
  logic         rerr;

  icache_refill_if #(.ADDR_WIDTH(64), .BEAT_WIDTH(32)) bus ();

  icache_refill_unit #(.ADDR_WIDTH(64), .BLOCK_WIDTH(512), .BEAT_WIDTH(32)) dut (
    .i_clk          (clk),
    .i_arst         (arst),
    .i_icache_miss  (miss),
    .i_read_addr    (raddr),
    .axi            (bus),
    .o_instr_we     (we),
    .o_instr_block  (blk),
    .o_busy         (busy),
    .o_refill_error (rerr)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           we_cnt, err_cnt, ar_bad, data_bad, fill_lat;
  bit           timed_out, fill_busy;
  logic [511:0] fill_block;
  logic [511:0] exp_block;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (we === 1'b1) we_cnt++;
    if (rerr === 1'b1) err_cnt++;
  endtask

  // Drives one miss and plays the memory side. Beat data is the beat index.
  // Negative err_beat/redir_beat/rst_beat disable that feature.
  task automatic run_burst(input logic [63:0] addr, input logic [63:0] line, input int ar_delay,
                           input bit gaps, input int err_beat, input int last_beat,
                           input int redir_beat, input logic [63:0] redir_addr, input int rst_beat);
    int k, guard, start;
    bit v;
    we_cnt = 0; err_cnt = 0; ar_bad = 0; data_bad = 0; timed_out = 0; fill_lat = -1;
    miss = 1'b1; raddr = addr; start = cyc;
    step();
    for (int i = 0; i <= ar_delay; i++) begin
      if (bus.o_axi_arvalid !== 1'b1 || bus.o_axi_araddr !== line) ar_bad++;
      bus.i_axi_arready = (i == ar_delay);
      step();
    end
    bus.i_axi_arready = 1'b0;
    k = 0; v = 1'b1; guard = 0;
    while (k <= last_beat && guard < 200) begin
      if (bus.o_axi_rready !== 1'b1 || bus.o_axi_arvalid !== 1'b0) data_bad++;
      if (k == redir_beat) raddr = redir_addr;
      bus.i_axi_rvalid = v;
      bus.i_axi_rdata  = 32'(k);
      bus.i_axi_rresp  = (k == err_beat) ? 2'b10 : 2'b00;
      bus.i_axi_rlast  = (k == last_beat);
      if (k == rst_beat && v) begin
        arst = 1'b1;
        step();
        arst = 1'b0; bus.i_axi_rvalid = 1'b0; bus.i_axi_rlast = 1'b0; miss = 1'b0;
        return;
      end
      step();
      if (v) k++;
      if (gaps) v = !v;
      guard++;
    end
    bus.i_axi_rvalid = 1'b0; bus.i_axi_rlast = 1'b0; bus.i_axi_rresp = 2'b00;
    if (guard >= 200) timed_out = 1'b1;
    fill_lat = cyc - start; fill_block = blk; fill_busy = busy;
    miss = 1'b0;
    step();
  endtask

  initial begin
    arst = 1'b1; miss = 1'b0; raddr = '0;
    bus.i_axi_arready = 1'b0; bus.i_axi_rvalid = 1'b0; bus.i_axi_rdata = '0;
    bus.i_axi_rresp = 2'b00; bus.i_axi_rlast = 1'b0;
    for (int k = 0; k < 16; k++) exp_block[32*k +: 32] = 32'(k);
    step(); step();
    `CHK("rst_arvalid", bus.o_axi_arvalid, 1'b0)
    `CHK("rst_rready", bus.o_axi_rready, 1'b0)
    `CHK("rst_we", we, 1'b0)
    `CHK("rst_err", rerr, 1'b0)
    `CHK("rst_busy", busy, 1'b0)
    `CHK("rst_araddr", bus.o_axi_araddr, 64'h0)
    `CHK("rst_block", blk, 512'h0)
    `CHK("arlen", bus.o_axi_arlen, 8'd15)
    `CHK("arsize", bus.o_axi_arsize, 3'd2)
    `CHK("arburst", bus.o_axi_arburst, 2'b01)
    arst = 1'b0;
    step();

    // Basic refill
    run_burst(64'h8000_1234, 64'h8000_1200, 0, 1'b0, -1, 15, -1, 64'h0, -1);
    `CHK("basic_timeout", timed_out, 1'b0)
    `CHK("basic_ar", ar_bad, 0)
    `CHK("basic_data_ch", data_bad, 0)
    `CHK("basic_latency", fill_lat, 18)
    `CHK("basic_fill_busy", fill_busy, 1'b1)
    `CHK("basic_block", fill_block, exp_block)
    `CHK("basic_we_cnt", we_cnt, 1)
    `CHK("basic_err_cnt", err_cnt, 0)
    `CHK("basic_idle_busy", busy, 1'b0)
    `CHK("basic_block_hold", blk, exp_block)

    // Backpressure: arready after 3 cycles, rvalid every other cycle
    run_burst(64'h8000_1234, 64'h8000_1200, 3, 1'b1, -1, 15, -1, 64'h0, -1);
    `CHK("bp_timeout", timed_out, 1'b0)
    `CHK("bp_ar_stable", ar_bad, 0)
    `CHK("bp_data_ch", data_bad, 0)
    `CHK("bp_latency", fill_lat, 36)
    `CHK("bp_block", fill_block, exp_block)
    `CHK("bp_we_cnt", we_cnt, 1)
    `CHK("bp_err_cnt", err_cnt, 0)

    // Error response on beat 5
    run_burst(64'h8000_1234, 64'h8000_1200, 0, 1'b0, 5, 15, -1, 64'h0, -1);
    `CHK("rresp_we_cnt", we_cnt, 0)
    `CHK("rresp_err_cnt", err_cnt, 1)
    `CHK("rresp_latency", fill_lat, 18)
    `CHK("rresp_idle_busy", busy, 1'b0)

    // Early rlast on beat 9
    run_burst(64'h8000_1234, 64'h8000_1200, 0, 1'b0, -1, 9, -1, 64'h0, -1);
    `CHK("early_we_cnt", we_cnt, 0)
    `CHK("early_err_cnt", err_cnt, 1)
    `CHK("early_latency", fill_lat, 12)
    `CHK("early_idle_busy", busy, 1'b0)

    // Stale miss: redirect to 0x8000_2000 at beat 8, then refill the new line
    run_burst(64'h8000_1234, 64'h8000_1200, 0, 1'b0, -1, 15, 8, 64'h8000_2000, -1);
    `CHK("stale_we_cnt", we_cnt, 0)
    `CHK("stale_err_cnt", err_cnt, 0)
    `CHK("stale_idle_busy", busy, 1'b0)
    run_burst(64'h8000_2000, 64'h8000_2000, 0, 1'b0, -1, 15, -1, 64'h0, -1);
    `CHK("redir_ar", ar_bad, 0)
    `CHK("redir_we_cnt", we_cnt, 1)
    `CHK("redir_err_cnt", err_cnt, 0)
    `CHK("redir_block", fill_block, exp_block)

    // Reset at beat 7, then a fresh refill
    run_burst(64'h8000_1234, 64'h8000_1200, 0, 1'b0, -1, 15, -1, 64'h0, 7);
    `CHK("mrst_arvalid", bus.o_axi_arvalid, 1'b0)
    `CHK("mrst_rready", bus.o_axi_rready, 1'b0)
    `CHK("mrst_we", we, 1'b0)
    `CHK("mrst_err", rerr, 1'b0)
    `CHK("mrst_busy", busy, 1'b0)
    `CHK("mrst_araddr", bus.o_axi_araddr, 64'h0)
    `CHK("mrst_block", blk, 512'h0)
    `CHK("mrst_arlen", bus.o_axi_arlen, 8'd15)
    run_burst(64'h8000_1234, 64'h8000_1200, 0, 1'b0, -1, 15, -1, 64'h0, -1);
    `CHK("post_rst_timeout", timed_out, 1'b0)
    `CHK("post_rst_latency", fill_lat, 18)
    `CHK("post_rst_we_cnt", we_cnt, 1)
    `CHK("post_rst_err_cnt", err_cnt, 0)
    `CHK("post_rst_block", fill_block, exp_block)

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
